gaus_window_writer: RTL and testbench

- Writer-side partner of the Gaussian 5x5 multiplier block. It consumes a raster-order 8-bit pixel stream and builds a sliding 5x5 window. It presents the window as five 40-bit row words (gausHoldOutA..E), together with a valid strobe and window coordinates.
- It sits between the pixel source (frame RAM reader) and the multiplier. It stores four previous image lines in line RAMs plus a 5x5 register window.

---
 rtl/gaus_window_writer_pkg.sv | 16 +
 rtl/gaus_line_ram.sv | 36 +++
 rtl/gaus_window_writer.sv | 160 ++++++++++++++++
 tb/tb_gaus_window_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaus_window_writer_pkg.sv
// Shared constants for the Gaussian 5x5 window writer and its multiplier partner.
// Provides the window geometry (taps, pixel width, row-word width) and the
// writer FSM state encoding.
package gaus_window_writer_pkg;

  localparam int GAUS_TAPS  = 5;
  localparam int PIX_W      = 8;
  localparam int ROW_WORD_W = GAUS_TAPS * PIX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gaus_state_e;

endpackage

// File: rtl/gaus_line_ram.sv
// Single-port line RAM, one image line of 8-bit pixels.
// Read-before-write: on an enabled cycle the old word at addr is captured in
// rdata while wdata is stored at the same address.
// Ports:
//   clk      rising-edge clock
//   en       access enable (read and write happen together)
//   addr     column address
//   wdata    pixel to store
//   old_data current contents at addr, feeds the next RAM of the line cascade
//   rdata    registered read data (value before this cycle's write)
module gaus_line_ram
  import gaus_window_writer_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  wdata,
  output logic [PIX_W-1:0]  old_data,
  output logic [PIX_W-1:0]  rdata
);

  logic [PIX_W-1:0] mem [0:DEPTH-1];

  assign old_data = mem[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= old_data;
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/gaus_window_writer.sv
// Sliding 5x5 window builder for the Gaussian multiplier.
// Consumes raster-order pixels, keeps four previous lines in a cascade of line
// RAMs and presents the window as five 40-bit row words, leftmost column in
// the top byte.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   startEn           arms a new frame, clears counters and pipeline valids
//   pixelIn/Valid     raster pixel stream; pixelValid low stalls everything
//   gausHoldOutA..E   window rows, A oldest line, E newest (current pixel)
//   windowValid       window lies fully inside the image this cycle
//   centreRow/Col     coordinates of the window centre pixel
//   frameDone         one-cycle pulse after the last pixel of the frame
module gaus_window_writer
  import gaus_window_writer_pkg::*;
#(
  parameter int IMGW = 2048,
  parameter int IMGH = 1024,
  parameter int PICW = 24,
  parameter int COLW = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startEn,
  input  logic [PIX_W-1:0]      pixelIn,
  input  logic                  pixelValid,
  output logic [ROW_WORD_W-1:0] gausHoldOutA,
  output logic [ROW_WORD_W-1:0] gausHoldOutB,
  output logic [ROW_WORD_W-1:0] gausHoldOutC,
  output logic [ROW_WORD_W-1:0] gausHoldOutD,
  output logic [ROW_WORD_W-1:0] gausHoldOutE,
  output logic                  windowValid,
  output logic [PICW-1:0]       centreRow,
  output logic [PICW-1:0]       centreCol,
  output logic                  frameDone
);

  localparam int LINES = GAUS_TAPS - 1;
  localparam int HALF  = GAUS_TAPS / 2;
  localparam int KEEP  = ROW_WORD_W - PIX_W;

  gaus_state_e     state, state_nxt;
  logic            accept;
  logic            last_beat;
  logic [COLW-1:0] col;
  logic [PICW-1:0] row;

  assign last_beat = (row == PICW'(IMGH - 1)) && (col == COLW'(IMGW - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // startEn takes precedence over a pixel beat in the same cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: if (startEn) state_nxt = RUN;
      RUN: begin
        if (!startEn && pixelValid) begin
          accept = 1'b1;
          if (last_beat) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || startEn) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COLW'(IMGW - 1)) begin
        col <= '0;
        row <= (row == PICW'(IMGH - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---- stage 1: line RAM cascade, Lk holds line row-k ----
  logic [PIX_W-1:0] chain [0:LINES];
  logic [PIX_W-1:0] ram_rd [0:LINES-1];

  assign chain[0] = pixelIn;

  for (genvar k = 0; k < LINES; k++) begin : g_line
    gaus_line_ram #(
      .DEPTH  (IMGW),
      .ADDR_W (COLW)
    ) u_ram (
      .clk      (clk),
      .en       (accept),
      .addr     (col),
      .wdata    (chain[k]),
      .old_data (chain[k+1]),
      .rdata    (ram_rd[k])
    );
  end

  logic             vld_p1;
  logic             ok_p1;
  logic [PIX_W-1:0] pix_p1;
  logic [PICW-1:0]  row_p1;
  logic [COLW-1:0]  col_p1;

  always_ff @(posedge clk) begin
    if (reset || startEn) vld_p1 <= 1'b0;
    else                  vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p1 <= pixelIn;
      ok_p1  <= (row >= PICW'(LINES)) && (col >= COLW'(LINES));
      row_p1 <= row;
      col_p1 <= col;
    end
  end

  // ---- stage 2: window shift, newest column enters at [7:0] ----
  logic shift_p2;
  assign shift_p2 = vld_p1 && !startEn;

  always_ff @(posedge clk) begin
    if (reset) begin
      gausHoldOutA <= '0;
      gausHoldOutB <= '0;
      gausHoldOutC <= '0;
      gausHoldOutD <= '0;
      gausHoldOutE <= '0;
      windowValid  <= 1'b0;
      centreRow    <= '0;
      centreCol    <= '0;
    end else begin
      windowValid <= shift_p2 && ok_p1;
      if (shift_p2) begin
        gausHoldOutA <= {gausHoldOutA[KEEP-1:0], ram_rd[3]};
        gausHoldOutB <= {gausHoldOutB[KEEP-1:0], ram_rd[2]};
        gausHoldOutC <= {gausHoldOutC[KEEP-1:0], ram_rd[1]};
        gausHoldOutD <= {gausHoldOutD[KEEP-1:0], ram_rd[0]};
        gausHoldOutE <= {gausHoldOutE[KEEP-1:0], pix_p1};
        if (ok_p1) begin
          centreRow <= row_p1 - PICW'(HALF);
          centreCol <= PICW'(col_p1) - PICW'(HALF);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) frameDone <= 1'b0;
    else       frameDone <= (state == DONE);
  end

endmodule

// File: tb/tb_gaus_window_writer.sv
// Self-checking bench for gaus_window_writer on an 8x6 image.
module tb_gaus_window_writer;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int PW = 24;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startEn = 1'b0;
  logic          pixelValid = 1'b0;
  logic [7:0]    pixelIn = 8'h00;
  logic [39:0]   gA, gB, gC, gD, gE;
  logic          windowValid, frameDone;
  logic [PW-1:0] centreRow, centreCol;

  always #5 clk = ~clk;

  gaus_window_writer #(
    .IMGW (W),
    .IMGH (H),
    .PICW (PW),
    .COLW (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startEn      (startEn),
    .pixelIn      (pixelIn),
    .pixelValid   (pixelValid),
    .gausHoldOutA (gA),
    .gausHoldOutB (gB),
    .gausHoldOutC (gC),
    .gausHoldOutD (gD),
    .gausHoldOutE (gE),
    .windowValid  (windowValid),
    .centreRow    (centreRow),
    .centreCol    (centreCol),
    .frameDone    (frameDone)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_win = 0;
  int n_fd  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  // One window row: line r, columns c-4 .. c, leftmost in the top byte.
  function automatic logic [39:0] wrow(input int r, input int c);
    logic [39:0] w = '0;
    for (int j = 0; j < 5; j++) w = {w[31:0], pix(r, c - 4 + j)};
    return w;
  endfunction

  // Reference model: which beat each output cycle reflects.
  typedef struct {
    int due;
    int r;
    int c;
  } beat_t;

  beat_t q[$];
  int ecount   = 0;
  bit chk_en   = 0;
  bit m_run    = 0;
  int mr       = 0;
  int mc       = 0;
  int fd_due   = -1;
  int rst_edge = -10;

  initial forever begin
    @(posedge clk);
    ecount++;
    if (reset) begin
      chk_en   = 1;
      m_run    = 0;
      q.delete();
      fd_due   = -1;
      rst_edge = ecount;
    end else if (startEn) begin
      m_run = 1;
      mr    = 0;
      mc    = 0;
      q.delete();
    end else if (m_run && pixelValid) begin
      q.push_back('{due: ecount + 1, r: mr, c: mc});
      if (mr == H - 1 && mc == W - 1) begin
        m_run  = 0;
        fd_due = ecount + 1;
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr + 1) % H;
      end else begin
        mc++;
      end
    end
  end

  logic [39:0]   pA, pB, pC, pD, pE;
  logic [PW-1:0] pR, pC2;

  initial forever begin
    beat_t b;
    bit    shifted;
    bit    exp_v;
    @(negedge clk);
    if (chk_en) begin
      shifted = 0;
      exp_v   = 0;
      if (q.size() > 0 && q[0].due == ecount) begin
        b       = q.pop_front();
        shifted = 1;
        exp_v   = (b.r >= 4) && (b.c >= 4);
      end
      chk("windowValid", 64'(windowValid), 64'(exp_v));
      chk("frameDone", 64'(frameDone), 64'(fd_due == ecount));
      if (windowValid === 1'b1) n_win++;
      if (frameDone === 1'b1) n_fd++;
      if (rst_edge == ecount) begin
        chk("rst_A", 64'(gA), 64'd0);
        chk("rst_C", 64'(gC), 64'd0);
        chk("rst_E", 64'(gE), 64'd0);
        chk("rst_row", 64'(centreRow), 64'd0);
        chk("rst_col", 64'(centreCol), 64'd0);
      end else if (exp_v) begin
        chk("win_A", 64'(gA), 64'(wrow(b.r - 4, b.c)));
        chk("win_B", 64'(gB), 64'(wrow(b.r - 3, b.c)));
        chk("win_C", 64'(gC), 64'(wrow(b.r - 2, b.c)));
        chk("win_D", 64'(gD), 64'(wrow(b.r - 1, b.c)));
        chk("win_E", 64'(gE), 64'(wrow(b.r, b.c)));
        chk("centreRow", 64'(centreRow), 64'(b.r - 2));
        chk("centreCol", 64'(centreCol), 64'(b.c - 2));
        if (b.r == 4 && b.c == 4) begin
          chk("first_A", 64'(gA), 64'h00_0001020304);
          chk("first_C", 64'(gC), 64'h00_2021222324);
          chk("first_E", 64'(gE), 64'h00_4041424344);
          chk("first_row", 64'(centreRow), 64'd2);
          chk("first_col", 64'(centreCol), 64'd2);
        end
        if (b.r == 5 && b.c == 4) begin
          chk("wrap_A", 64'(gA), 64'h00_1011121314);
          chk("wrap_row", 64'(centreRow), 64'd3);
          chk("wrap_col", 64'(centreCol), 64'd2);
        end
        if (b.r == 4 && b.c == 6) chk("stall_E", 64'(gE), 64'h00_4243444546);
      end else begin
        chk("hold_row", 64'(centreRow), 64'(pR));
        chk("hold_col", 64'(centreCol), 64'(pC2));
        if (!shifted) begin
          chk("hold_A", 64'(gA), 64'(pA));
          chk("hold_B", 64'(gB), 64'(pB));
          chk("hold_C", 64'(gC), 64'(pC));
          chk("hold_D", 64'(gD), 64'(pD));
          chk("hold_E", 64'(gE), 64'(pE));
        end
      end
      pA = gA; pB = gB; pC = gC; pD = gD; pE = gE;
      pR = centreRow; pC2 = centreCol;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] p);
    pixelValid = 1'b1;
    pixelIn    = p;
    tick();
    pixelValid = 1'b0;
  endtask

  task automatic idle(input int n);
    pixelValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start();
    startEn = 1'b1;
    tick();
    startEn = 1'b0;
  endtask

  // Full frame; a 3-cycle stall follows beat (sr, sc) when it exists.
  task automatic run_frame(input int sr, input int sc);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        beat(pix(r, c));
        if (r == sr && c == sc) idle(3);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    idle(2);

    // Frame with a stall after (4,5), then pixels while DONE/IDLE.
    n_win = 0; n_fd = 0;
    start();
    run_frame(4, 5);
    for (int i = 0; i < 10; i++) beat(8'hE0 + 8'(i));
    idle(3);
    chk("frame1_windows", 64'(n_win), 64'd8);
    chk("frame1_done", 64'(n_fd), 64'd1);

    // Restart at beat (4,2), then a complete frame.
    n_win = 0; n_fd = 0;
    start();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W && !(r == 4 && c == 2); c++) beat(pix(r, c));
    startEn    = 1'b1;
    pixelValid = 1'b1;
    pixelIn    = pix(4, 2);
    tick();
    startEn    = 1'b0;
    pixelValid = 1'b0;
    run_frame(-1, -1);
    idle(3);
    chk("restart_windows", 64'(n_win), 64'd8);
    chk("restart_done", 64'(n_fd), 64'd1);

    // Reset mid-frame; afterwards the block must stay idle until startEn.
    start();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < W && !(r == 4 && c == 6); c++) beat(pix(r, c));
    reset      = 1'b1;
    pixelValid = 1'b1;
    tick();
    reset      = 1'b0;
    pixelValid = 1'b0;
    n_win = 0; n_fd = 0;
    run_frame(-1, -1);
    idle(3);
    chk("idle_windows", 64'(n_win), 64'd0);
    chk("idle_done", 64'(n_fd), 64'd0);

    n_win = 0; n_fd = 0;
    start();
    run_frame(-1, -1);
    idle(3);
    chk("post_reset_windows", 64'(n_win), 64'd8);
    chk("post_reset_done", 64'(n_fd), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
